// File: rtl/apb_cfg_slave.sv
// ---------------------------------------------------------------------------
// apb_cfg_slave
//
// APB3 configuration slave for an arbiter. It holds the arbiter control
// word, the requester enable mask and a sticky grant-status register, and
// reports a fixed identification byte.
//
// Register map (8-bit data bus):
//    0x00  CTRL     RW   bits[3:0], upper bits read as 0
//                        bit0 drives APB_BYPASS, bits[3:1] drive APB_ARB_TYPE
//    0x01  REQ      RW   bits[NUM_REQ-1:0], drives APB_REQ
//    0x02  GNT_STS  W1C  bit i sets whenever ARB_GNT[i] is seen high
//    0x03  ID       RO   {4'h1, NUM_REQ[3:0]}
//    other addresses are unmapped and read as 0
//
// Transfer protocol:
//    The slave walks IDLE -> SETUP -> ACCESS. SETUP is entered on the APB
//    setup phase (PSEL & ~PENABLE). The first enable cycle moves the FSM to
//    ACCESS, where a wait counter counts up to WAIT_CYCLES before PREADY is
//    raised. The transfer completes on the edge where PREADY is seen with
//    PSEL & PENABLE still high. Dropping PSEL or PENABLE before that edge
//    abandons the transfer without touching any register.
//
// Optional feature (compile-time macro):
//    APB_CFG_SLAVE_PSLVERR_EN
//       defined   : PSLVERR is raised together with PREADY on an error
//                   transfer (address >= 0x04, or a write to ID).
//       undefined : PSLVERR is tied low; error transfers still complete
//                   silently with no register change and PRDATA = 0.
//
// Parameters:
//    NUM_REQ      number of arbiter requesters (1..8)
//    WAIT_CYCLES  wait states inserted in ACCESS before PREADY (0..3)
//
// Ports:
//    PCLK          in   1        clock
//    PRESETn       in   1        asynchronous active-low reset
//    PADDR         in   8        register address
//    PSEL          in   1        slave select
//    PENABLE       in   1        enable phase
//    PWRITE        in   1        1 = write, 0 = read
//    PWDATA        in   8        write data
//    PRDATA        out  8        read data (0 unless a read is completing)
//    PREADY        out  1        transfer completion
//    PSLVERR       out  1        transfer error
//    ARB_GNT       in   NUM_REQ  grant vector from the arbiter
//    APB_BYPASS    out  1        CTRL[0]
//    APB_ARB_TYPE  out  3        CTRL[3:1]
//    APB_REQ       out  NUM_REQ  REQ[NUM_REQ-1:0]
// ---------------------------------------------------------------------------
module apb_cfg_slave #(
   parameter int NUM_REQ     = 4,
   parameter int WAIT_CYCLES = 0
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic [7:0]         PADDR,
   input  logic               PSEL,
   input  logic               PENABLE,
   input  logic               PWRITE,
   input  logic [7:0]         PWDATA,
   output logic [7:0]         PRDATA,
   output logic               PREADY,
   output logic               PSLVERR,
   input  logic [NUM_REQ-1:0] ARB_GNT,
   output logic               APB_BYPASS,
   output logic [2:0]         APB_ARB_TYPE,
   output logic [NUM_REQ-1:0] APB_REQ
);

   localparam logic [7:0] ADDR_CTRL  = 8'h00;
   localparam logic [7:0] ADDR_REQ   = 8'h01;
   localparam logic [7:0] ADDR_GNT   = 8'h02;
   localparam logic [7:0] ADDR_ID    = 8'h03;
   localparam logic [7:0] ADDR_LIMIT = 8'h04;

   localparam logic [1:0] WAIT_LIM   = 2'(WAIT_CYCLES);
   localparam logic [3:0] NUM_REQ_4  = 4'(NUM_REQ);
   localparam logic [7:0] ID_VALUE   = {4'h1, NUM_REQ_4};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apbState_e;

   apbState_e          stateQ,   stateD;
   logic [1:0]         waitCntQ, waitCntD;
   logic               readyQ,   readyD;
   logic [3:0]         ctrlQ,    ctrlD;
   logic [NUM_REQ-1:0] reqQ,     reqD;
   logic [NUM_REQ-1:0] gntStsQ,  gntStsD;

   logic               errXfer;
   logic               xferDone;
   logic               wrEn;
   logic [NUM_REQ-1:0] gntClr;
   logic [7:0]         reqRd;
   logic [7:0]         gntRd;
   logic [7:0]         rdMux;
   logic               unusedPwdata;

   // An error transfer is any access outside the map or a write to the
   // read-only ID register. It is evaluated from the live bus signals,
   // which APB holds stable for the whole transfer.
   always_comb begin
      errXfer = (PADDR >= ADDR_LIMIT) || (PWRITE && (PADDR == ADDR_ID));
   end

   // The completion edge is the only point where a write may land. Error
   // transfers complete normally on the bus but never reach the registers,
   // whether or not PSLVERR reporting is built in.
   always_comb begin
      xferDone = (stateQ == ACCESS) && PSEL && PENABLE && readyQ;
      wrEn     = xferDone && PWRITE && !errXfer;
   end

   // Next-state logic for the transfer FSM and its wait counter. The counter
   // is cleared whenever ACCESS is left or has not yet been entered, so each
   // transfer starts counting from zero. If the master withdraws PSEL or
   // PENABLE before completion, the FSM falls back to IDLE.
   always_comb begin
      stateD   = stateQ;
      waitCntD = waitCntQ;
      case (stateQ)
         IDLE: begin
            waitCntD = 2'd0;
            if (PSEL && !PENABLE) begin
               stateD = SETUP;
            end
         end
         SETUP: begin
            waitCntD = 2'd0;
            if (PSEL && PENABLE) begin
               stateD = ACCESS;
            end else begin
               stateD = IDLE;
            end
         end
         ACCESS: begin
            if (PSEL && PENABLE) begin
               if (readyQ) begin
                  waitCntD = 2'd0;
                  stateD   = (PSEL && !PENABLE) ? SETUP : IDLE;
               end else begin
                  waitCntD = waitCntQ + 2'd1;
               end
            end else begin
               waitCntD = 2'd0;
               stateD   = IDLE;
            end
         end
         default: begin
            waitCntD = 2'd0;
            stateD   = IDLE;
         end
      endcase
   end

   // PREADY is registered: it is computed from the next state and counter so
   // that it is high exactly in the ACCESS cycle whose counter equals
   // WAIT_CYCLES, and it drops to 0 directly with the asynchronous reset.
   always_comb begin
      readyD = (stateD == ACCESS) && (waitCntD == WAIT_LIM);
   end

   // Register-file next state. For GNT_STS a grant seen on the same edge as
   // a write-one-to-clear keeps the bit set, because the set term is OR-ed
   // in after the clear mask is applied.
   always_comb begin
      ctrlD  = ctrlQ;
      reqD   = reqQ;
      gntClr = '0;
      if (wrEn && (PADDR == ADDR_CTRL)) begin
         ctrlD = PWDATA[3:0];
      end
      if (wrEn && (PADDR == ADDR_REQ)) begin
         reqD = PWDATA[NUM_REQ-1:0];
      end
      if (wrEn && (PADDR == ADDR_GNT)) begin
         gntClr = PWDATA[NUM_REQ-1:0];
      end
      gntStsD = (gntStsQ & ~gntClr) | ARB_GNT;
   end

   // All sequential state, including the FSM, lives in this one block. Reset
   // is asynchronous so a reset in the middle of a transfer abandons it
   // immediately and no write can slip through on a later edge.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         stateQ   <= IDLE;
         waitCntQ <= 2'd0;
         readyQ   <= 1'b0;
         ctrlQ    <= 4'd0;
         reqQ     <= '0;
         gntStsQ  <= '0;
      end else begin
         stateQ   <= stateD;
         waitCntQ <= waitCntD;
         readyQ   <= readyD;
         ctrlQ    <= ctrlD;
         reqQ     <= reqD;
         gntStsQ  <= gntStsD;
      end
   end

   // Read mux. Narrow registers are zero-extended to the 8-bit bus, and any
   // address outside the map returns 0.
   always_comb begin
      reqRd = '0;
      gntRd = '0;
      reqRd[NUM_REQ-1:0] = reqQ;
      gntRd[NUM_REQ-1:0] = gntStsQ;
      case (PADDR)
         ADDR_CTRL: rdMux = {4'h0, ctrlQ};
         ADDR_REQ:  rdMux = reqRd;
         ADDR_GNT:  rdMux = gntRd;
         ADDR_ID:   rdMux = ID_VALUE;
         default:   rdMux = 8'h00;
      endcase
   end

   // PRDATA is only driven while a read is actually completing, so the bus
   // reads 0 during idle, wait states, writes and reset.
   always_comb begin
      PRDATA = (readyQ && !PWRITE) ? rdMux : 8'h00;
   end

   assign PREADY = readyQ;

`ifdef APB_CFG_SLAVE_PSLVERR_EN
   assign PSLVERR = readyQ && errXfer;
`else
   assign PSLVERR = 1'b0;
`endif

   assign APB_BYPASS   = ctrlQ[0];
   assign APB_ARB_TYPE = ctrlQ[3:1];
   assign APB_REQ      = reqQ;

   // Only the low bits of PWDATA are stored; the rest is intentionally
   // ignored.
   assign unusedPwdata = &{1'b0, PWDATA};

endmodule

// File: tb/tb_apb_cfg_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_cfg_slave
//
// Self-checking bench for apb_cfg_slave built with NUM_REQ=4, WAIT_CYCLES=2.
// Each APB transfer pushes its expected read data and error flag onto a
// scoreboard queue; the entry is popped and compared when PREADY appears.
// A small register model (ctrlM, reqM, gntM) supplies expected values.
// ---------------------------------------------------------------------------
module tb_apb_cfg_slave;

   localparam int NUM_REQ     = 4;
   localparam int WAIT_CYCLES = 2;

`ifdef APB_CFG_SLAVE_PSLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic               PCLK = 1'b0;
   logic               PRESETn = 1'b1;
   logic [7:0]         PADDR = 8'h00;
   logic               PSEL = 1'b0;
   logic               PENABLE = 1'b0;
   logic               PWRITE = 1'b0;
   logic [7:0]         PWDATA = 8'h00;
   logic [7:0]         PRDATA;
   logic               PREADY;
   logic               PSLVERR;
   logic [NUM_REQ-1:0] ARB_GNT = '0;
   logic               APB_BYPASS;
   logic [2:0]         APB_ARB_TYPE;
   logic [NUM_REQ-1:0] APB_REQ;

   typedef struct {
      string      tag;
      logic [7:0] rdata;
      logic       err;
   } sbEntry_t;

   sbEntry_t sbQueue[$];

   int errorCount = 0;
   int checkCount = 0;

   logic [3:0] ctrlM = 4'h0;
   logic [3:0] reqM  = 4'h0;
   logic [3:0] gntM  = 4'h0;

   apb_cfg_slave #(
      .NUM_REQ     (NUM_REQ),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .PADDR        (PADDR),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PWRITE       (PWRITE),
      .PWDATA       (PWDATA),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .PSLVERR      (PSLVERR),
      .ARB_GNT      (ARB_GNT),
      .APB_BYPASS   (APB_BYPASS),
      .APB_ARB_TYPE (APB_ARB_TYPE),
      .APB_REQ      (APB_REQ)
   );

   // 100 MHz clock
   always #5 PCLK = ~PCLK;

   // Compare one observed value against the expected one and tally it
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Expected read value of a register from the model
   function automatic logic [7:0] modelRead(input logic [7:0] addr);
      case (addr)
         8'h00:   return {4'h0, ctrlM};
         8'h01:   return {4'h0, reqM};
         8'h02:   return {4'h0, gntM};
         8'h03:   return 8'h14;
         default: return 8'h00;
      endcase
   endfunction

   // Apply a completed write to the model; ARB_GNT is the bench's own stimulus
   task automatic modelWrite(input logic [7:0] addr, input logic [7:0] data);
      case (addr)
         8'h00:   ctrlM = data[3:0];
         8'h01:   reqM  = data[3:0];
         8'h02:   gntM  = (gntM & ~data[3:0]) | ARB_GNT;
         default: ;
      endcase
   endtask

   // Register-driven outputs against the model
   task automatic checkPorts(input string tag);
      checkOutput({tag, "_bypass"}, 32'(APB_BYPASS), 32'(ctrlM[0]));
      checkOutput({tag, "_arbType"}, 32'(APB_ARB_TYPE), 32'(ctrlM[3:1]));
      checkOutput({tag, "_req"}, 32'(APB_REQ), 32'(reqM));
   endtask

   // One full APB transfer with scoreboard push/pop and latency check
   task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                input logic [7:0] data, input string tag);
      sbEntry_t exp;
      sbEntry_t got;
      logic     isErr;
      int       cycles;
      logic     seen;
      isErr     = (addr >= 8'h04) || (wr && (addr == 8'h03));
      exp.tag   = tag;
      exp.rdata = (wr || isErr) ? 8'h00 : modelRead(addr);
      exp.err   = ERR_EN && isErr;
      sbQueue.push_back(exp);
      @(posedge PCLK);
      #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PADDR   = addr;
      PWRITE  = wr;
      PWDATA  = data;
      @(posedge PCLK);
      #1;
      PENABLE = 1'b1;
      cycles  = 0;
      seen    = 1'b0;
      while (!seen && cycles < 20) begin
         @(negedge PCLK);
         cycles++;
         if (PREADY === 1'b1) seen = 1'b1;
      end
      got = sbQueue.pop_front();
      checkOutput({got.tag, "_ready"}, 32'(seen), 32'd1);
      checkOutput({got.tag, "_rdata"}, 32'(PRDATA), 32'(got.rdata));
      checkOutput({got.tag, "_err"}, 32'(PSLVERR), 32'(got.err));
      checkOutput({got.tag, "_latency"}, 32'(cycles), 32'(WAIT_CYCLES + 2));
      @(posedge PCLK);
      if (seen && wr && !isErr) modelWrite(addr, data);
      #1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      @(negedge PCLK);
      checkOutput({tag, "_readyLow"}, 32'(PREADY), 32'd0);
      checkPorts(tag);
   endtask

   // One-cycle grant pulse
   task automatic pulseGnt(input logic [3:0] v);
      @(posedge PCLK);
      #1;
      ARB_GNT = v;
      @(posedge PCLK);
      gntM = gntM | v;
      #1;
      ARB_GNT = '0;
   endtask

   // Main sequence
   initial begin
      int  cycles;
      logic seen;

      // Reset state
      #1 PRESETn = 1'b0;
      #2;
      checkOutput("rst_pready", 32'(PREADY), 32'd0);
      checkOutput("rst_pslverr", 32'(PSLVERR), 32'd0);
      checkOutput("rst_prdata", 32'(PRDATA), 32'd0);
      checkPorts("rst");
      repeat (2) @(posedge PCLK);
      #2 PRESETn = 1'b1;
      @(negedge PCLK);
      checkOutput("idle_prdata", 32'(PRDATA), 32'd0);

      // CTRL write/read
      applyStimulus(1'b1, 8'h00, 8'h0B, "ctrlWr");
      checkOutput("ctrlWr_bypassVal", 32'(APB_BYPASS), 32'd1);
      checkOutput("ctrlWr_arbVal", 32'(APB_ARB_TYPE), 32'b101);
      applyStimulus(1'b0, 8'h00, 8'h00, "ctrlRd");

      // REQ write/read with masking
      applyStimulus(1'b1, 8'h01, 8'hFF, "reqWr");
      applyStimulus(1'b0, 8'h01, 8'h00, "reqRd");
      checkOutput("reqRd_reqVal", 32'(APB_REQ), 32'hF);

      // GNT_STS set, set-wins-over-clear, clear
      applyStimulus(1'b0, 8'h02, 8'h00, "gntRd0");
      pulseGnt(4'b0100);
      applyStimulus(1'b0, 8'h02, 8'h00, "gntRdSet");
      ARB_GNT = 4'b0100;
      applyStimulus(1'b1, 8'h02, 8'h04, "gntClrColl");
      ARB_GNT = 4'b0000;
      applyStimulus(1'b0, 8'h02, 8'h00, "gntRdKept");
      applyStimulus(1'b1, 8'h02, 8'h04, "gntClr");
      applyStimulus(1'b0, 8'h02, 8'h00, "gntRdClr");
      pulseGnt(4'b1001);
      applyStimulus(1'b1, 8'h02, 8'h01, "gntClrBit0");
      applyStimulus(1'b0, 8'h02, 8'h00, "gntRdBit3");

      // Error transfers
      applyStimulus(1'b1, 8'h03, 8'hAA, "idWr");
      applyStimulus(1'b0, 8'h07, 8'h00, "unmapRd");
      applyStimulus(1'b0, 8'h03, 8'h00, "idRd");
      applyStimulus(1'b1, 8'h05, 8'h00, "unmapWr");
      applyStimulus(1'b0, 8'h00, 8'h00, "ctrlAfterErr");
      applyStimulus(1'b0, 8'h01, 8'h00, "reqAfterErr");

      // Abort a write by dropping PENABLE in a wait state
      applyStimulus(1'b1, 8'h00, 8'h00, "ctrlZero");
      @(posedge PCLK);
      #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PADDR   = 8'h00;
      PWRITE  = 1'b1;
      PWDATA  = 8'h01;
      @(posedge PCLK);
      #1 PENABLE = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      checkOutput("abort_wait", 32'(PREADY), 32'd0);
      @(posedge PCLK);
      #1 PENABLE = 1'b0;
      @(negedge PCLK);
      checkOutput("abort_drop", 32'(PREADY), 32'd0);
      @(posedge PCLK);
      #1 PSEL = 1'b0;
      repeat (2) @(posedge PCLK);
      applyStimulus(1'b0, 8'h00, 8'h00, "abortCtrlRd");

      // Reset in the middle of a completing read
      applyStimulus(1'b1, 8'h00, 8'hFF, "ctrlAll");
      applyStimulus(1'b1, 8'h01, 8'h05, "reqSome");
      @(posedge PCLK);
      #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PADDR   = 8'h00;
      PWRITE  = 1'b0;
      @(posedge PCLK);
      #1 PENABLE = 1'b1;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < 20) begin
         @(negedge PCLK);
         cycles++;
         if (PREADY === 1'b1) seen = 1'b1;
      end
      checkOutput("midRst_ready", 32'(seen), 32'd1);
      checkOutput("midRst_preRd", 32'(PRDATA), 32'(modelRead(8'h00)));
      #1 PRESETn = 1'b0;
      #1;
      ctrlM = 4'h0;
      reqM  = 4'h0;
      gntM  = 4'h0;
      checkOutput("midRst_pready", 32'(PREADY), 32'd0);
      checkOutput("midRst_prdata", 32'(PRDATA), 32'd0);
      checkOutput("midRst_pslverr", 32'(PSLVERR), 32'd0);
      checkPorts("midRst");
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      repeat (2) @(posedge PCLK);
      #2 PRESETn = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00, "postRstCtrl");
      applyStimulus(1'b0, 8'h01, 8'h00, "postRstReq");
      applyStimulus(1'b0, 8'h02, 8'h00, "postRstGnt");

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
